// File: rtl/tri_port_regfile_lookup_ctrl_if.sv
// tri_port_regfile_lookup_ctrl_if: lookup request/response channels plus the regfile CAM/write port.
interface tri_port_regfile_lookup_ctrl_if #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int NUM_ENTRY = 4
);
    logic                                  request_valid_in;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_key_in;
    logic                                  request_ready_out;
    logic                                  response_valid_out;
    logic                                  response_hit_out;
    logic [NUM_ENTRY-1:0]                  response_index_decoded_out;
    logic                                  response_ready_in;
    logic                                  cam_en_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] cam_entry_out;
    logic                                  write_en_out;
    logic [NUM_ENTRY-1:0]                  write_entry_addr_decoded_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_out;
    logic [NUM_ENTRY-1:0]                  cam_result_decoded_in;

    modport master (
        output request_valid_in, request_key_in, response_ready_in, cam_result_decoded_in,
        input  request_ready_out, response_valid_out, response_hit_out, response_index_decoded_out,
        input  cam_en_out, cam_entry_out, write_en_out, write_entry_addr_decoded_out, write_entry_out
    );
    modport slave (
        input  request_valid_in, request_key_in, response_ready_in, cam_result_decoded_in,
        output request_ready_out, response_valid_out, response_hit_out, response_index_decoded_out,
        output cam_en_out, cam_entry_out, write_en_out, write_entry_addr_decoded_out, write_entry_out
    );
endinterface

// File: rtl/tri_port_regfile_lookup_ctrl.sv
// tri_port_regfile_lookup_ctrl: CAM lookup controller that inserts misses into a regfile with round-robin replacement.
module tri_port_regfile_lookup_ctrl #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int NUM_ENTRY = 4
) (
    input logic clk_in,
    input logic reset_in,
    input logic flush_in,
    tri_port_regfile_lookup_ctrl_if.slave bus
);
    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int N = NUM_ENTRY;

    typedef enum logic [2:0] {IDLE, SEARCH, EVAL, WRITE, RESP} state_t;

    state_t         state, next;
    logic [W-1:0]   key_q;
    logic [N-1:0]   valid_q, rr_q, idx_q, hit_vec, hit_low, inv, victim;
    logic           hit_q, live, accept;

    // reset and flush both suppress every output combinationally so nothing leaks on the abort edge
    assign live    = ~reset_in & ~flush_in;
    assign accept  = bus.request_valid_in & bus.request_ready_out;
    assign hit_vec = bus.cam_result_decoded_in & valid_q;
    assign hit_low = hit_vec & -hit_vec;
    assign inv     = ~valid_q;
    assign victim  = &valid_q ? rr_q : inv & -inv;

    always_ff @(posedge clk_in)
        state <= (reset_in | flush_in) ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? SEARCH : IDLE;
            SEARCH:  next = EVAL;
            EVAL:    next = |hit_vec ? RESP : WRITE;
            WRITE:   next = RESP;
            RESP:    next = bus.response_ready_in ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in | flush_in) begin
            valid_q <= '0;
            rr_q    <= {{(N-1){1'b0}}, 1'b1};
            key_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (accept)
                key_q <= bus.request_key_in;
            if (state == EVAL) begin
                hit_q <= |hit_vec;
                idx_q <= |hit_vec ? hit_low : victim;
                if (~|hit_vec & &valid_q)
                    rr_q <= {rr_q[N-2:0], rr_q[N-1]};
            end
            if (state == WRITE)
                valid_q <= valid_q | idx_q;
        end
    end

    always_comb begin
        bus.request_ready_out            = live & (state == IDLE);
        bus.cam_en_out                   = live & (state == SEARCH);
        bus.cam_entry_out                = bus.cam_en_out ? key_q : '0;
        bus.write_en_out                 = live & (state == WRITE);
        bus.write_entry_addr_decoded_out = bus.write_en_out ? idx_q : '0;
        bus.write_entry_out              = bus.write_en_out ? key_q : '0;
        bus.response_valid_out           = live & (state == RESP);
        bus.response_hit_out             = bus.response_valid_out & hit_q;
        bus.response_index_decoded_out   = bus.response_valid_out ? idx_q : '0;
    end
endmodule
